// File: rtl/dmem_lsu_pkg.sv
// Shared widths, funct3 opcodes and access helpers for the data memory LSU.
package dmem_lsu_pkg;

  localparam int W_B = 8;
  localparam int W_H = 16;
  localparam int W_W = 32;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  // Bit n set means funct3 value n is not a legal load/store width (011, 110, 111).
  localparam logic [7:0] ILLEGAL_OP_MASK = 8'b1100_1000;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  // Illegal encodings, unsigned stores and misaligned halves/words all fault.
  function automatic logic access_fault(logic we, logic [2:0] op, logic [1:0] lo);
    logic f;
    f = ILLEGAL_OP_MASK[op];
    if (we && (op == OP_BU || op == OP_HU)) f = 1'b1;
    if ((op == OP_H || op == OP_HU) && lo[0]) f = 1'b1;
    if (op == OP_W && lo != 2'b00) f = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] op, logic [1:0] lo);
    logic [3:0] be;
    case (op)
      OP_B:    be = 4'b0001 << lo;
      OP_H:    be = lo[1] ? 4'b1100 : 4'b0011;
      OP_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [W_W-1:0] store_data(logic [2:0] op, logic [W_W-1:0] wd);
    logic [W_W-1:0] d;
    case (op)
      OP_B:    d = {4{wd[W_B-1:0]}};
      OP_H:    d = {2{wd[W_H-1:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [W_W-1:0] load_extend(logic [2:0] op, logic [1:0] lo,
                                                 logic [W_W-1:0] word);
    logic [W_W-1:0] sh;
    logic [W_B-1:0] b;
    logic [W_H-1:0] h;
    logic [W_W-1:0] r;
    sh = word >> {lo, 3'b000};
    b  = sh[W_B-1:0];
    h  = lo[1] ? word[W_W-1:W_H] : word[W_H-1:0];
    case (op)
      OP_B:    r = {{(W_W-W_B){b[W_B-1]}}, b};
      OP_H:    r = {{(W_W-W_H){h[W_H-1]}}, h};
      OP_BU:   r = {{(W_W-W_B){1'b0}}, b};
      OP_HU:   r = {{(W_W-W_H){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the MEM stage and the LSU.
interface dmem_lsu_if;
  import dmem_lsu_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [2:0]     req_op;
  logic [W_W-1:0] req_addr;
  logic [W_W-1:0] req_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W_W-1:0] rsp_rdata;
  logic           rsp_err;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_bank.sv
// Word-organised RAM with byte-lane write enables and a one-cycle registered read.
module dmem_bank #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  // Contents are never reset; they start at zero from elaboration.
  logic [31:0] mem [DEPTH] = '{default: '0};

  // Lane writes and read-before-write registered read of the addressed word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-lane data RAM: one outstanding access,
// READ_LAT-cycle response latency, lane stores, load extension and faults.
module dmem_lsu import dmem_lsu_pkg::*; #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned READ_LAT  = 1
) (
  input logic        clk,
  input logic        rst_n,
  dmem_lsu_if.slave  bus
);

  localparam int unsigned WORD_BITS = ADDR_BITS - 2;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 started_q;
  logic                 ready;
  logic                 accept;
  logic                 rsp_load;
  logic                 req_fault;

  logic                 we_q;
  logic [2:0]           op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 err_q;

  logic [W_W-1:0]       rdata_q;
  logic                 rsp_err_q;

  logic [3:0]           bank_we;
  logic [WORD_BITS-1:0] bank_addr;
  logic [W_W-1:0]       bank_wdata;
  logic [W_W-1:0]       bank_rdata;

  // Address bits above the decoded range alias onto the low memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[W_W-1:ADDR_BITS];

  assign accept    = bus.req_valid & ready;
  assign req_fault = access_fault(bus.req_we, bus.req_op, bus.req_addr[1:0]);

  // Stores commit on the accept edge; idle cycles read the incoming address.
  assign bank_we    = (accept && bus.req_we && !req_fault) ?
                      byte_en(bus.req_op, bus.req_addr[1:0]) : 4'b0000;
  assign bank_addr  = (state_q == StIdle) ? bus.req_addr[ADDR_BITS-1:2] :
                      addr_q[ADDR_BITS-1:2];
  assign bank_wdata = store_data(bus.req_op, bus.req_wdata);

  dmem_bank #(
    .DEPTH (2 ** WORD_BITS)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (bank_rdata)
  );

  // Next-state, latency countdown and handshake outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rsp_load = 1'b0;
    ready    = started_q && (state_q == StIdle);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = 4'(READ_LAT - 1);
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d  = StResp;
          rsp_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; started_q keeps req_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
    end
  end

  // Capture the request attributes on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      op_q   <= 3'b000;
      addr_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      we_q   <= bus.req_we;
      op_q   <= bus.req_op;
      addr_q <= bus.req_addr[ADDR_BITS-1:0];
      err_q  <= req_fault;
    end
  end

  // Register the response once; it is held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else if (rsp_load) begin
      rdata_q   <= (err_q || we_q) ? '0 : load_extend(op_q, addr_q[1:0], bank_rdata);
      rsp_err_q <= err_q;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (READ_LAT 1 and 4) see identical requests;
// a byte-array model predicts responses and an edge-counting protocol model
// predicts req_ready/rsp_valid, compared every cycle on the falling edge.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready [2];

  logic        dut_ready [2];
  logic        dut_valid [2];
  logic        dut_err [2];
  logic [31:0] dut_rdata [2];

  int checks = 0;
  int failures = 0;
  string cur_name = "reset";

  logic [7:0]  mem_model [1024];
  int          m_state [2];   // 0 idle, 1 waiting for latency, 2 response shown
  int          m_wait [2];
  bit          m_started [2];
  logic [31:0] m_rdata [2];
  logic        m_err [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned LAT = (g == 0) ? 1 : 4;
    dmem_lsu_if bus ();
    assign bus.req_valid = req_valid;
    assign bus.req_we    = req_we;
    assign bus.req_op    = req_op;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.rsp_ready = rsp_ready[g];
    assign dut_ready[g]  = bus.req_ready;
    assign dut_valid[g]  = bus.rsp_valid;
    assign dut_err[g]    = bus.rsp_err;
    assign dut_rdata[g]  = bus.rsp_rdata;

    dmem_lsu #(
      .ADDR_BITS (10),
      .READ_LAT  (LAT)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int lane_lat(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic check32(string what, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", cur_name, what, act, exp);
    end
  endtask

  task automatic check1(string what, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %b expected %b", cur_name, what, act, exp);
    end
  endtask

  // Little-endian byte memory; returns the response and applies a legal store.
  function automatic void model_access(input logic we, input logic [2:0] op,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
    int a, n;
    bit sgn;
    a = int'(addr[9:0]);
    sgn = 1'b0;
    case (op)
      3'd0:    begin n = 1; sgn = 1'b1; end
      3'd1:    begin n = 2; sgn = 1'b1; end
      3'd2:    n = 4;
      3'd4:    n = 1;
      3'd5:    n = 2;
      default: n = 0;
    endcase
    err = (n == 0) || (we && op >= 3'd4) || ((a % (n == 0 ? 1 : n)) != 0);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mem_model[a + k] = 8'(wd >> (8 * k));
      end else begin
        for (int k = 0; k < n; k++) rd = rd | (32'(mem_model[a + k]) << (8 * k));
        if (sgn && rd[8 * n - 1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 1'b0;
      m_state[i]   = 0;
      m_wait[i]    = 0;
      rsp_ready[i] = 1'b0;
    end
  endtask

  // Protocol model advanced at each rising edge from the bench's own inputs.
  task automatic model_step();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      if (!m_started[i]) begin
        m_started[i] = 1'b1;
      end else begin
        case (m_state[i])
          0: if (req_valid) begin
               m_state[i] = 1;
               m_wait[i]  = lane_lat(i);
             end
          1: begin
               m_wait[i] = m_wait[i] - 1;
               if (m_wait[i] == 0) m_state[i] = 2;
             end
          default: if (rsp_ready[i]) m_state[i] = 0;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check1($sformatf("req_ready[%0d]", i), dut_ready[i],
             m_started[i] && (m_state[i] == 0));
      check1($sformatf("rsp_valid[%0d]", i), dut_valid[i], m_state[i] == 2);
      if (m_state[i] == 2) begin
        check32($sformatf("rsp_rdata[%0d]", i), dut_rdata[i], m_rdata[i]);
        check1($sformatf("rsp_err[%0d]", i), dut_err[i], m_err[i]);
      end
      if (!rst_n) begin
        check32($sformatf("reset rsp_rdata[%0d]", i), dut_rdata[i], 32'h0);
        check1($sformatf("reset rsp_err[%0d]", i), dut_err[i], 1'b0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!(m_started[0] && m_started[1] && m_state[0] == 0 && m_state[1] == 0)
           && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      failures++;
      $display("FAIL %s idle wait: timed out after %0d cycles, required idle", cur_name, budget);
    end
  endtask

  // Predict and pin the response, present the request, then drain both lanes.
  task automatic present(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] lit_rd,
                         input logic lit_err);
    logic [31:0] rd;
    logic e;
    wait_idle();
    model_access(we, op, addr, wdata, rd, e);
    check32("model rdata", rd, lit_rd);
    check1("model err", e, lit_err);
    for (int i = 0; i < 2; i++) begin
      m_rdata[i] = rd;
      m_err[i]   = e;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    req_op    = OP_W;
  endtask

  task automatic txn(input string name, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                     input int hold, input logic [31:0] lit_rd, input logic lit_err);
    int budget, hold_left;
    int stall_left [2];
    cur_name = name;
    present(we, op, addr, wdata, lit_rd, lit_err);
    stall_left[0] = stall;
    stall_left[1] = stall;
    hold_left = hold;
    budget = 0;
    while ((m_state[0] != 0 || m_state[1] != 0) && budget < 60) begin
      for (int i = 0; i < 2; i++) begin
        if (m_state[i] == 2 && stall_left[i] == 0) begin
          rsp_ready[i] = 1'b1;
        end else begin
          rsp_ready[i] = 1'b0;
          if (m_state[i] == 2) stall_left[i]--;
        end
      end
      req_valid = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      tick();
      budget++;
    end
    if (budget >= 60) begin
      checks++;
      failures++;
      $display("FAIL %s drain: timed out after %0d cycles, required response", name, budget);
    end
    req_valid = 1'b0;
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem_model[k] = 8'h00;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    txn("sw_deadbeef", 1'b1, OP_W,  32'h10,  32'hDEADBEEF, 0, 0, 32'h0,        1'b0);
    txn("lw_10",       1'b0, OP_W,  32'h10,  32'h0,        0, 0, 32'hDEADBEEF, 1'b0);
    txn("sb_80",       1'b1, OP_B,  32'h21,  32'h80,       0, 0, 32'h0,        1'b0);
    txn("lb_21",       1'b0, OP_B,  32'h21,  32'h0,        0, 0, 32'hFFFFFF80, 1'b0);
    txn("lbu_21",      1'b0, OP_BU, 32'h21,  32'h0,        0, 0, 32'h00000080, 1'b0);
    txn("lw_20",       1'b0, OP_W,  32'h20,  32'h0,        0, 0, 32'h00008000, 1'b0);
    txn("sh_mis",      1'b1, OP_H,  32'h13,  32'h1234,     0, 0, 32'h0,        1'b1);
    txn("lw_10_again", 1'b0, OP_W,  32'h10,  32'h0,        0, 0, 32'hDEADBEEF, 1'b0);
    txn("lw_mis",      1'b0, OP_W,  32'h22,  32'h0,        0, 0, 32'h0,        1'b1);
    txn("lw_stall",    1'b0, OP_W,  32'h10,  32'h0,        3, 2, 32'hDEADBEEF, 1'b0);
    txn("lh_10",       1'b0, OP_H,  32'h10,  32'h0,        0, 0, 32'hFFFFBEEF, 1'b0);
    txn("lhu_12",      1'b0, OP_HU, 32'h12,  32'h0,        1, 0, 32'h0000DEAD, 1'b0);
    txn("lb_13",       1'b0, OP_B,  32'h13,  32'h0,        0, 0, 32'hFFFFFFDE, 1'b0);
    txn("lbu_10",      1'b0, OP_BU, 32'h10,  32'h0,        0, 0, 32'h000000EF, 1'b0);
    txn("sw_wrap",     1'b1, OP_W,  32'h404, 32'hCAFEF00D, 0, 0, 32'h0,        1'b0);
    txn("lw_wrap",     1'b0, OP_W,  32'h004, 32'h0,        0, 0, 32'hCAFEF00D, 1'b0);
    txn("st_op110",    1'b1, 3'b110, 32'h8,  32'h55555555, 0, 0, 32'h0,        1'b1);
    txn("ld_op011",    1'b0, 3'b011, 32'h8,  32'h0,        0, 0, 32'h0,        1'b1);
    txn("st_bu",       1'b1, OP_BU, 32'h8,   32'h77,       0, 0, 32'h0,        1'b1);
    txn("lw_8",        1'b0, OP_W,  32'h8,   32'h0,        0, 0, 32'h0,        1'b0);
    txn("sh_16",       1'b1, OP_H,  32'h16,  32'h5678ABCD, 0, 0, 32'h0,        1'b0);
    txn("lw_14",       1'b0, OP_W,  32'h14,  32'h0,        0, 0, 32'hABCD0000, 1'b0);
    txn("lh_16",       1'b0, OP_H,  32'h16,  32'h0,        2, 0, 32'hFFFFABCD, 1'b0);

    // Reset while both instances are busy with an accepted store.
    cur_name = "sw_reset";
    present(1'b1, OP_W, 32'h30, 32'h11223344, 32'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    txn("lw_after_rst", 1'b0, OP_W, 32'h30, 32'h0, 0, 0, 32'h11223344, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
